kyber_spm_mul: RTL and testbench

Parametrised serial-parallel multiplier for the Kyber arithmetic datapath. It produces the full 2·WIDTH-bit product of two WIDTH-bit operands, signed or unsigned, selected per operation. The result is produced one bit per clock through a bit-slice SPM core. Operands are latched on a valid/ready input handshake and the result is held on a valid/ready output handshake, so the block sits between the polynomial-coefficient fetch stage and the reduction stage without external sequencing.

---
 rtl/kyber_pkg.sv | 18 +
 rtl/kyber_spm_mul_if.sv | 23 ++
 rtl/kyber_spm_core.sv | 46 ++++
 rtl/kyber_spm_mul.sv | 108 ++++++++++
 tb/tb_kyber_spm_mul.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/kyber_pkg.sv
// rtl/kyber_pkg.sv - shared types and parameter helpers for the Kyber SPM multiplier
package kyber_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 4;
    localparam int WIDTH_MAX = 64;

    // Counter must reach 2*WIDTH, the terminal step count.
    function automatic int cnt_width(input int width);
        return $clog2(2 * width + 1);
    endfunction

endpackage

// File: rtl/kyber_spm_mul_if.sv
// rtl/kyber_spm_mul_if.sv - operand/product handshake bundle for kyber_spm_mul
interface kyber_spm_mul_if #(
    parameter int WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_signed;
    logic [WIDTH-1:0]     in_mc;
    logic [WIDTH-1:0]     in_mp;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_p;

    modport master (
        output in_valid, in_signed, in_mc, in_mp, out_ready,
        input  in_ready, out_valid, out_p
    );

    modport slave (
        input  in_valid, in_signed, in_mc, in_mp, out_ready,
        output in_ready, out_valid, out_p
    );
endinterface

// File: rtl/kyber_spm_core.sv
// rtl/kyber_spm_core.sv - (WIDTH+1)-bit signed serial-parallel bit-slice multiplier array
module kyber_spm_core #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           en,
    input  logic [WIDTH:0] x,
    input  logic           y,
    output logic           p
);
    logic [WIDTH:1]   s;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] pp;
    logic [WIDTH-1:0] fsum;
    logic [WIDTH-1:0] fcar;
    logic             seen;
    logic             top;

    // Slice i adds its partial-product bit to the running sum of slice i+1.
    assign pp   = x[WIDTH-1:0] & {WIDTH{y}};
    assign fsum = pp ^ s ^ c;
    assign fcar = (pp & s) | (pp & c) | (s & c);
    assign p    = fsum[0];

    // Top slice carries negative weight: serial two's-complement of its stream.
    assign top = x[WIDTH] & y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s    <= '0;
            c    <= '0;
            seen <= 1'b0;
        end else if (clr) begin
            s    <= '0;
            c    <= '0;
            seen <= 1'b0;
        end else if (en) begin
            s    <= {top ^ seen, fsum[WIDTH-1:1]};
            c    <= fcar;
            seen <= seen | top;
        end
    end

endmodule

// File: rtl/kyber_spm_mul.sv
// rtl/kyber_spm_mul.sv - handshaked serial-parallel multiplier top; optional SPM_ZERO_SKIP_EN
module kyber_spm_mul
    import kyber_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    kyber_spm_mul_if.slave bus,
    output logic           busy
);
    localparam int             CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(2 * WIDTH);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("kyber_spm_mul: WIDTH out of range");
    end

    state_t             state;
    state_t             state_nx;
    logic [WIDTH:0]     mc;
    logic [WIDTH:0]     y_sr;
    logic [2*WIDTH-1:0] p_sr;
    logic [2*WIDTH-1:0] p_out;
    logic [CNT_W-1:0]   cnt;
    logic               skip;
    logic               accept;
    logic               step;
    logic               done;
    logic               zero_op;
    logic               core_p;
    logic [WIDTH:0]     ext_mc;
    logic [WIDTH:0]     ext_mp;

    assign ext_mc = {bus.in_signed & bus.in_mc[WIDTH-1], bus.in_mc};
    assign ext_mp = {bus.in_signed & bus.in_mp[WIDTH-1], bus.in_mp};

`ifdef SPM_ZERO_SKIP_EN
    assign zero_op = (bus.in_mc == '0) || (bus.in_mp == '0);
`else
    assign zero_op = 1'b0;
`endif

    assign accept = bus.in_valid && bus.in_ready;
    assign step   = (state == RUN) && (cnt != LAST);
    assign done   = (state == RUN) && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = RUN;
            RUN:  if (done)   state_nx = HOLD;
            HOLD: begin
                if (accept)             state_nx = RUN;
                else if (bus.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE) || ((state == HOLD) && bus.out_ready);
        bus.out_valid = (state == HOLD);
        busy          = (state == RUN) && !skip;
    end

    // A skipped operation parks cnt at LAST so RUN lasts one cycle and P stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mc    <= '0;
            y_sr  <= '0;
            p_sr  <= '0;
            p_out <= '0;
            cnt   <= '0;
            skip  <= 1'b0;
        end else if (accept) begin
            mc   <= ext_mc;
            y_sr <= ext_mp;
            p_sr <= '0;
            cnt  <= zero_op ? LAST : '0;
            skip <= zero_op;
        end else if (step) begin
            y_sr <= {y_sr[WIDTH], y_sr[WIDTH:1]};
            p_sr <= {core_p, p_sr[2*WIDTH-1:1]};
            cnt  <= cnt + CNT_W'(1);
        end else if (done) begin
            p_out <= p_sr;
        end
    end

    assign bus.out_p = p_out;

    kyber_spm_core #(.WIDTH(WIDTH)) u_core (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (step),
        .x   (mc),
        .y   (y_sr[0]),
        .p   (core_p)
    );

endmodule

// File: tb/tb_kyber_spm_mul.sv
// tb/tb_kyber_spm_mul.sv - directed self-checking bench for kyber_spm_mul (WIDTH 32 and 16)
module tb_kyber_spm_mul;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy32;
    logic busy16;
    int   errors = 0;
    int   checks = 0;

    kyber_spm_mul_if #(.WIDTH(32)) b32 ();
    kyber_spm_mul_if #(.WIDTH(16)) b16 ();

    kyber_spm_mul #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(b32), .busy(busy32));
    kyber_spm_mul #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16), .busy(busy16));

    always #5 clk = ~clk;

`ifdef SPM_ZERO_SKIP_EN
    localparam int  ZERO_LAT  = 1;
    localparam logic ZERO_BUSY = 1'b0;
`else
    localparam int  ZERO_LAT  = 65;
    localparam logic ZERO_BUSY = 1'b1;
`endif

    task automatic op32(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] p, output int lat, output logic saw_busy);
        @(negedge clk);
        b32.in_signed = sgn;
        b32.in_mc     = a;
        b32.in_mp     = b;
        b32.in_valid  = 1'b1;
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
        b32.in_mc    = ~a;
        b32.in_mp    = ~b;
        lat      = 0;
        saw_busy = busy32;
        while (!b32.out_valid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
            saw_busy |= busy32;
        end
        p = b32.out_p;
    endtask

    task automatic consume32();
        @(negedge clk);
        b32.out_ready = 1'b1;
        @(posedge clk); #1;
        b32.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (b32.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready32: got %b want 1", b32.in_ready); end
        checks++; if (b32.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid32: got %b want 0", b32.out_valid); end
        checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL reset_busy32: got %b want 0", busy32); end
        checks++; if (b32.out_p !== 64'h0) begin errors++; $display("FAIL reset_out_p32: got %h want 0", b32.out_p); end
        checks++; if (b16.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready16: got %b want 1", b16.in_ready); end
        checks++; if (b16.out_p !== 32'h0) begin errors++; $display("FAIL reset_out_p16: got %h want 0", b16.out_p); end
    endtask

    task automatic test_products();
        logic        sg [6];
        logic [31:0] av [6];
        logic [31:0] bv [6];
        logic [63:0] ev [6];
        logic [63:0] p;
        int          lat;
        logic        sb;
        sg[0] = 1'b1; av[0] = 32'hFFFF_FFFD; bv[0] = 32'd7;         ev[0] = 64'hFFFF_FFFF_FFFF_FFEB;
        sg[1] = 1'b0; av[1] = 32'hFFFF_FFFF; bv[1] = 32'hFFFF_FFFF; ev[1] = 64'hFFFF_FFFE_0000_0001;
        sg[2] = 1'b1; av[2] = 32'hFFFF_FFFF; bv[2] = 32'hFFFF_FFFF; ev[2] = 64'h0000_0000_0000_0001;
        sg[3] = 1'b1; av[3] = 32'h8000_0000; bv[3] = 32'h8000_0000; ev[3] = 64'h4000_0000_0000_0000;
        sg[4] = 1'b1; av[4] = 32'h8000_0000; bv[4] = 32'h7FFF_FFFF; ev[4] = 64'hC000_0000_8000_0000;
        sg[5] = 1'b0; av[5] = 32'h8000_0000; bv[5] = 32'h8000_0000; ev[5] = 64'h4000_0000_0000_0000;
        for (int i = 0; i < 6; i++) begin
            op32(sg[i], av[i], bv[i], p, lat, sb);
            checks++; if (lat !== 65) begin errors++; $display("FAIL latency32[%0d]: got %0d want 65", i, lat); end
            checks++; if (p !== ev[i]) begin errors++; $display("FAIL product32[%0d]: got %h want %h", i, p, ev[i]); end
            checks++; if (sb !== 1'b1) begin errors++; $display("FAIL busy_seen32[%0d]: got %b want 1", i, sb); end
            consume32();
            checks++; if (b32.out_valid !== 1'b0) begin errors++; $display("FAIL drained32[%0d]: got %b want 0", i, b32.out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        b16.in_signed = 1'b0;
        b16.in_mc     = 16'd3328;
        b16.in_mp     = 16'd3328;
        b16.in_valid  = 1'b1;
        @(posedge clk); #1;
        b16.in_valid = 1'b0;
        lat = 0;
        while (!b16.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        checks++; if (lat !== 33) begin errors++; $display("FAIL latency16: got %0d want 33", lat); end
        checks++; if (b16.out_p !== 32'h00A9_0000) begin errors++; $display("FAIL product16: got %h want 00a90000", b16.out_p); end
        @(negedge clk);
        b16.in_mc    = 16'd100;
        b16.in_mp    = 16'd200;
        b16.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++; if (b16.out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b want 1", i, b16.out_valid); end
            checks++; if (b16.out_p !== 32'h00A9_0000) begin errors++; $display("FAIL hold_out_p[%0d]: got %h want 00a90000", i, b16.out_p); end
            checks++; if (b16.in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready[%0d]: got %b want 0", i, b16.in_ready); end
        end
        @(negedge clk);
        b16.out_ready = 1'b1;
        #1;
        checks++; if (b16.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b want 1", b16.in_ready); end
        @(posedge clk); #1;
        b16.in_valid  = 1'b0;
        b16.out_ready = 1'b0;
        checks++; if (busy16 !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", busy16); end
        checks++; if (b16.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop: got %b want 0", b16.out_valid); end
        checks++; if (b16.out_p !== 32'h00A9_0000) begin errors++; $display("FAIL b2b_retain: got %h want 00a90000", b16.out_p); end
        lat = 0;
        while (!b16.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency: got %0d want 33", lat); end
        checks++; if (b16.out_p !== 32'd20000) begin errors++; $display("FAIL b2b_product: got %h want 00004e20", b16.out_p); end
        @(negedge clk);
        b16.out_ready = 1'b1;
        @(posedge clk); #1;
        b16.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] p;
        int          lat;
        logic        sb;
        @(negedge clk);
        b32.in_signed = 1'b1;
        b32.in_mc     = 32'hFFFF_FFFD;
        b32.in_mp     = 32'd7;
        b32.in_valid  = 1'b1;
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++; if (b32.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", b32.out_valid); end
        checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy32); end
        checks++; if (b32.out_p !== 64'h0) begin errors++; $display("FAIL rst_out_p: got %h want 0", b32.out_p); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (b32.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", b32.in_ready); end
        op32(1'b0, 32'd5, 32'd6, p, lat, sb);
        checks++; if (lat !== 65) begin errors++; $display("FAIL post_rst_latency: got %0d want 65", lat); end
        checks++; if (p !== 64'd30) begin errors++; $display("FAIL post_rst_product: got %h want 1e", p); end
        consume32();
    endtask

    task automatic test_zero_skip();
        logic [63:0] p;
        int          lat;
        logic        sb;
        op32(1'b0, 32'h0, 32'h1234, p, lat, sb);
        checks++; if (lat !== ZERO_LAT) begin errors++; $display("FAIL zero_latency: got %0d want %0d", lat, ZERO_LAT); end
        checks++; if (p !== 64'h0) begin errors++; $display("FAIL zero_product: got %h want 0", p); end
        checks++; if (sb !== ZERO_BUSY) begin errors++; $display("FAIL zero_busy: got %b want %b", sb, ZERO_BUSY); end
        consume32();
    endtask

    initial begin
        b32.in_valid = 1'b0; b32.in_signed = 1'b0; b32.in_mc = '0; b32.in_mp = '0; b32.out_ready = 1'b0;
        b16.in_valid = 1'b0; b16.in_signed = 1'b0; b16.in_mc = '0; b16.in_mp = '0; b16.out_ready = 1'b0;
        test_reset();
        test_products();
        test_back_to_back();
        test_reset_mid_run();
        test_zero_skip();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
